equiv_check_ctrl: RTL and testbench

//  Sequences a golden-vs-post-route equivalence run in synthesizable form.
//  - Drives one shared stimulus bus into a golden model and into the fabric netlist.
//  - Vector order: an exhaustive sweep of all 2^IN_W vectors, then NUM_RANDOM LFSR vectors.
//  - Waits SETTLE cycles per vector, then compares the two outputs and counts mismatches.
//  - Sits between the stimulus/clock domain and the two DUT instances in post-route test harnesses.

---
 rtl/equiv_pkg.sv | 22 ++
 rtl/equiv_lfsr.sv | 38 +++
 rtl/equiv_check_ctrl.sv | 175 +++++++++++++++++
 tb/tb_equiv_check_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/equiv_pkg.sv
`default_nettype none
// equiv_pkg: shared types and constants for the equivalence-check controller.
// Rev 1.0
package equiv_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    SETTLE  = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef enum logic {
    SWEEP  = 1'b0,
    RANDOM = 1'b1
  } phase_t;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage
`default_nettype wire

// File: rtl/equiv_lfsr.sv
`default_nettype none
// equiv_lfsr: 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting.
// Rev 1.0
module equiv_lfsr
  import equiv_pkg::*;
#(
  parameter logic [15:0] RST_SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] q
);

  localparam logic [15:0] c_TAPS = 16'hB400;

  logic [15:0] r_q;
  logic [15:0] w_seed;

  // An all-zero state would lock the register, so zero seeds fall back to the default.
  assign w_seed = (seed == 16'h0000) ? DEFAULT_SEED : seed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= (RST_SEED == 16'h0000) ? DEFAULT_SEED : RST_SEED;
    end else if (load) begin
      r_q <= w_seed;
    end else if (adv) begin
      r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? c_TAPS : 16'h0000);
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/equiv_check_ctrl.sv
`default_nettype none
// equiv_check_ctrl: drives exhaustive-then-LFSR stimulus into golden and netlist, counts mismatches.
// Rev 1.0
module equiv_check_ctrl
  import equiv_pkg::*;
#(
  parameter int          IN_W       = 2,
  parameter int          OUT_W      = 1,
  parameter int          SETTLE     = 1,
  parameter int          NUM_RANDOM = 500,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OUT_W-1:0] golden_i,
  input  logic [OUT_W-1:0] netlist_i,
  output logic [IN_W-1:0]  stim_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch_stb,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [IN_W-1:0]  first_fail
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int RND_W = (NUM_RANDOM > 1) ? $clog2(NUM_RANDOM) : 1;

  localparam logic [15:0]      c_SEED        = (LFSR_SEED == 16'h0000) ? DEFAULT_SEED : LFSR_SEED;
  localparam logic [SET_W-1:0] c_SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [RND_W-1:0] c_RND_LAST    = RND_W'((NUM_RANDOM > 0) ? NUM_RANDOM - 1 : 0);
  localparam logic [IN_W-1:0]  c_SWEEP_LAST  = {IN_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_MAX     = {CNT_W{1'b1}};

  // The SETTLE parameter hides the imported state name, so states are always package-qualified.
  state_t            r_state;
  state_t            w_next_state;
  phase_t            r_phase;
  logic [IN_W-1:0]   r_idx;
  logic [RND_W-1:0]  r_rnd_cnt;
  logic [SET_W-1:0]  r_set_cnt;
  logic [IN_W-1:0]   r_stim;
  logic [CNT_W-1:0]  r_vec_cnt;
  logic [CNT_W-1:0]  r_mis_cnt;
  logic [IN_W-1:0]   r_first_fail;

  logic [15:0]       w_lfsr_q;
  logic              w_lfsr_load;
  logic              w_lfsr_adv;
  logic [IN_W-1:0]   w_vector;
  logic              w_mismatch;
  logic              w_start_ok;
  logic              w_last_vec;

  equiv_lfsr #(
    .RST_SEED (c_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (w_lfsr_load),
    .seed (c_SEED),
    .adv  (w_lfsr_adv),
    .q    (w_lfsr_q)
  );

  assign w_start_ok  = start && ((r_state == equiv_pkg::IDLE) || (r_state == equiv_pkg::DONE));
  assign w_lfsr_load = w_start_ok;
  assign w_lfsr_adv  = (r_state == equiv_pkg::DRIVE) && (r_phase == RANDOM);
  assign w_vector    = (r_phase == SWEEP) ? r_idx : IN_W'(w_lfsr_q);

  // Case inequality so that any X/Z on either side is reported as a mismatch in simulation.
  assign w_mismatch  = (golden_i !== netlist_i);

  assign w_last_vec  = (r_phase == SWEEP) ? ((r_idx == c_SWEEP_LAST) && (NUM_RANDOM == 0))
                                          : (r_rnd_cnt == c_RND_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= equiv_pkg::IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      equiv_pkg::IDLE, equiv_pkg::DONE: begin
        if (start) w_next_state = equiv_pkg::DRIVE;
      end
      equiv_pkg::DRIVE:   w_next_state = equiv_pkg::SETTLE;
      equiv_pkg::SETTLE: begin
        if (r_set_cnt == '0) w_next_state = equiv_pkg::COMPARE;
      end
      equiv_pkg::COMPARE: w_next_state = w_last_vec ? equiv_pkg::DONE : equiv_pkg::DRIVE;
      default:            w_next_state = equiv_pkg::IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    pass         = 1'b0;
    mismatch_stb = 1'b0;
    case (r_state)
      equiv_pkg::DRIVE, equiv_pkg::SETTLE: busy = 1'b1;
      equiv_pkg::COMPARE: begin
        busy         = 1'b1;
        mismatch_stb = w_mismatch;
      end
      equiv_pkg::DONE: begin
        done = 1'b1;
        pass = (r_mis_cnt == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase      <= SWEEP;
      r_idx        <= '0;
      r_rnd_cnt    <= '0;
      r_set_cnt    <= '0;
      r_stim       <= '0;
      r_vec_cnt    <= '0;
      r_mis_cnt    <= '0;
      r_first_fail <= '0;
    end else begin
      case (r_state)
        equiv_pkg::IDLE, equiv_pkg::DONE: begin
          if (start) begin
            r_phase      <= SWEEP;
            r_idx        <= '0;
            r_rnd_cnt    <= '0;
            r_vec_cnt    <= '0;
            r_mis_cnt    <= '0;
            r_first_fail <= '0;
          end
        end
        equiv_pkg::DRIVE: begin
          r_stim    <= w_vector;
          r_set_cnt <= c_SETTLE_LAST;
        end
        equiv_pkg::SETTLE: begin
          if (r_set_cnt != '0) r_set_cnt <= r_set_cnt - 1'b1;
        end
        equiv_pkg::COMPARE: begin
          r_vec_cnt <= r_vec_cnt + 1'b1;
          if (w_mismatch) begin
            if (r_mis_cnt != c_CNT_MAX) r_mis_cnt <= r_mis_cnt + 1'b1;
            if (r_mis_cnt == '0) r_first_fail <= r_stim;
          end
          if (r_phase == SWEEP) begin
            if (r_idx == c_SWEEP_LAST) r_phase <= RANDOM;
            else                       r_idx   <= r_idx + 1'b1;
          end else begin
            r_rnd_cnt <= r_rnd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign stim_o       = r_stim;
  assign mismatch_cnt = r_mis_cnt;
  assign vec_cnt      = r_vec_cnt;
  assign first_fail   = r_first_fail;

endmodule
`default_nettype wire

// File: tb/tb_equiv_check_ctrl.sv
`default_nettype none
// tb_equiv_check_ctrl: directed self-checking bench for equiv_check_ctrl.
// Rev 1.0
module tb_equiv_check_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic use_or = 1'b0;
  int   n_checks = 0;
  int   n_errs   = 0;

  always #5 clk = ~clk;

  // A: and2 golden vs and2/or2 netlist, SETTLE=1, 8 random vectors
  logic [1:0]  stim_a, ff_a;
  logic        busy_a, done_a, pass_a, stb_a;
  logic [15:0] mis_a, vec_a;
  logic [0:0]  gold_a, net_a;
  assign gold_a = stim_a[0] & stim_a[1];
  assign net_a  = use_or ? (stim_a[0] | stim_a[1]) : (stim_a[0] & stim_a[1]);

  equiv_check_ctrl #(.IN_W(2), .OUT_W(1), .SETTLE(1), .NUM_RANDOM(8), .LFSR_SEED(16'hACE1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .golden_i(gold_a), .netlist_i(net_a),
    .stim_o(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a), .mismatch_stb(stb_a),
    .mismatch_cnt(mis_a), .vec_cnt(vec_a), .first_fail(ff_a));

  // B: SETTLE=3, sweep only
  logic [1:0]  stim_b, ff_b;
  logic        busy_b, done_b, pass_b, stb_b;
  logic [15:0] mis_b, vec_b;
  logic [0:0]  gold_b, net_b;
  assign gold_b = stim_b[0] & stim_b[1];
  assign net_b  = stim_b[0] & stim_b[1];

  equiv_check_ctrl #(.IN_W(2), .OUT_W(1), .SETTLE(3), .NUM_RANDOM(0), .LFSR_SEED(16'hACE1), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .golden_i(gold_b), .netlist_i(net_b),
    .stim_o(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b), .mismatch_stb(stb_b),
    .mismatch_cnt(mis_b), .vec_cnt(vec_b), .first_fail(ff_b));

  // C: 2-bit counters, netlist always wrong
  logic [1:0]  stim_c, ff_c;
  logic        busy_c, done_c, pass_c, stb_c;
  logic [1:0]  mis_c, vec_c;
  logic [0:0]  gold_c, net_c;
  assign gold_c = stim_c[0] & stim_c[1];
  assign net_c  = ~(stim_c[0] & stim_c[1]);

  equiv_check_ctrl #(.IN_W(2), .OUT_W(1), .SETTLE(1), .NUM_RANDOM(4), .LFSR_SEED(16'hACE1), .CNT_W(2)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .golden_i(gold_c), .netlist_i(net_c),
    .stim_o(stim_c), .busy(busy_c), .done(done_c), .pass(pass_c), .mismatch_stb(stb_c),
    .mismatch_cnt(mis_c), .vec_cnt(vec_c), .first_fail(ff_c));

  // Sweep 0..3, then low two bits of ACE1,E270,7138,389C,1C4E,0E27,B313,ED89
  int exp_stim [12] = '{0, 1, 2, 3, 1, 0, 0, 0, 2, 3, 3, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit and_or_differ(input int s);
    return (s == 1) || (s == 2);
  endfunction

  // Full run on A; extra_n>0 pulses start again so it is sampled in a COMPARE cycle
  task automatic run_a(input bit or_mode, input int extra_n);
    int   n_mis;
    int   ff;
    bit   seen;
    logic exp_stb;
    n_mis = 0; ff = 0; seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (or_mode && and_or_differ(exp_stim[k])) begin
        if (!seen) ff = exp_stim[k];
        seen = 1;
        n_mis++;
      end
    end
    use_or = or_mode;
    @(negedge clk);
    start_a = 1'b1;
    for (int n = 1; n <= 37; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) start_a = 1'b0;
      if (extra_n > 0 && n == extra_n)     start_a = 1'b1;
      if (extra_n > 0 && n == extra_n + 1) start_a = 1'b0;
      if (n == 1) begin
        check("a_busy_at_drive", busy_a, 1);
        check("a_done_cleared", done_a, 0);
        check("a_mis_cleared", mis_a, 0);
        check("a_vec_cleared", vec_a, 0);
      end
      if (n >= 2 && (n - 2) % 3 == 0)
        check($sformatf("a_stim%0d", (n - 2) / 3), stim_a, exp_stim[(n - 2) / 3]);
      exp_stb = (n % 3 == 0) && or_mode && and_or_differ(exp_stim[n / 3 - 1]);
      check($sformatf("a_stb_c%0d", n), stb_a, exp_stb);
      if (n == 36) begin
        check("a_done_early", done_a, 0);
        check("a_busy_before_done", busy_a, 1);
      end
      if (n == 37) begin
        check("a_done", done_a, 1);
        check("a_busy_in_done", busy_a, 0);
        check("a_vec_cnt", vec_a, 12);
        check("a_mis_cnt", mis_a, n_mis);
        check("a_pass", pass_a, (n_mis == 0));
        check("a_first_fail", ff_a, ff);
      end
    end
  endtask

  initial begin
    int n_done;

    repeat (3) @(negedge clk);
    check("rst_outputs_a", {stim_a, busy_a, done_a, pass_a, stb_a, mis_a, vec_a, ff_a}, 0);
    check("rst_outputs_c", {stim_c, busy_c, done_c, pass_c, stb_c, mis_c, vec_c, ff_c}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_not_busy", busy_a, 0);

    run_a(1'b0, 0);
    run_a(1'b1, 0);

    // Reset during SETTLE of vector 2
    use_or = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) start_a = 1'b0;
    end
    check("pre_rst_stim", stim_a, 2);
    check("pre_rst_vec", vec_a, 2);
    check("pre_rst_mis", mis_a, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_outputs", {stim_a, busy_a, done_a, pass_a, stb_a, mis_a, vec_a, ff_a}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_a(1'b0, 0);

    // Start during COMPARE ignored, then restart from DONE
    run_a(1'b1, 3);
    run_a(1'b1, 0);

    // Start and reset together
    @(negedge clk);
    rst = 1'b1;
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_wins_busy", busy_a, 0);
    check("rst_wins_done", done_a, 0);
    rst = 1'b0;
    start_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_wins_idle", busy_a, 0);

    // B: SETTLE=3, 4 vectors of 5 cycles
    n_done = 0;
    start_b = 1'b1;
    for (int n = 1; n <= 60 && n_done == 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) start_b = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (n == 2 + 5 * k) check($sformatf("b_stim%0d", k), stim_b, k);
        if (k >= 1 && n == 1 + 5 * k) check($sformatf("b_hold%0d", k - 1), stim_b, k - 1);
      end
      if (n == 20) check("b_busy_before_done", busy_b, 1);
      if (done_b) begin
        n_done = n;
        check("b_busy_in_done", busy_b, 0);
      end
    end
    check("b_done_cycle", n_done, 21);
    check("b_vec_cnt", vec_b, 4);
    check("b_pass", pass_b, 1);

    // C: every vector mismatches, 2-bit counters
    @(negedge clk);
    n_done = 0;
    start_c = 1'b1;
    for (int n = 1; n <= 60 && n_done == 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) start_c = 1'b0;
      if (done_c) n_done = n;
    end
    check("c_done_cycle", n_done, 25);
    check("c_mis_saturated", mis_c, 3);
    check("c_vec_wrapped", vec_c, 0);
    check("c_pass", pass_c, 0);
    check("c_first_fail", ff_c, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
